// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHalted
    } state_e;

    localparam int unsigned IDX_IFID = 0;
    localparam int unsigned IDX_IDEX = 1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: PC/stage enables and flushes, halt drain sequence and perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STAGES = 5,
    parameter int unsigned RA_W   = 3,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_wait,
    input  logic              jump_ex,
    input  logic              halt_id,
    input  logic [RA_W-1:0]   rs1_id,
    input  logic [RA_W-1:0]   rs2_id,
    input  logic              rs1_use_id,
    input  logic              rs2_use_id,
    input  logic [RA_W-1:0]   rd_ex,
    input  logic              ex_is_load,
    output logic              en_pc,
    output logic [STAGES-2:0] en_stage,
    output logic [STAGES-2:0] flush_stage,
    output logic              flushed,
    output logic              is_halt,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned DW = $clog2(STAGES);

    state_e          state_q, state_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            is_halt_q;
    logic            load_use;

    // r0 is an ordinary register, so no zero-register exemption here.
    assign load_use = ex_is_load &&
                      ((rs1_use_id && (rs1_id == rd_ex)) || (rs2_use_id && (rs2_id == rd_ex)));

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        en_pc       = 1'b1;
        en_stage    = '1;
        flush_stage = '0;
        flushed     = 1'b0;

        if (state_q == StHalted) begin
            en_pc    = 1'b0;
            en_stage = '0;
        end else if (mem_wait) begin
            en_pc    = 1'b0;
            en_stage = '0;
        end else if (jump_ex) begin
            // A jump during drain means the HLT was on the wrong path.
            flush_stage[IDX_IFID] = 1'b1;
            flush_stage[IDX_IDEX] = 1'b1;
            flushed               = 1'b1;
            state_d               = StRun;
            drain_d               = '0;
        end else if (state_q == StDrain) begin
            en_pc                 = 1'b0;
            flush_stage[IDX_IFID] = 1'b1;
            if (drain_q <= DW'(1)) begin
                state_d = StHalted;
                drain_d = '0;
            end else begin
                drain_d = drain_q - 1'b1;
            end
        end else if (load_use) begin
            en_pc                 = 1'b0;
            en_stage[IDX_IFID]    = 1'b0;
            flush_stage[IDX_IDEX] = 1'b1;
        end else if (halt_id) begin
            en_pc                 = 1'b0;
            flush_stage[IDX_IFID] = 1'b1;
            state_d               = StDrain;
            drain_d               = DW'(STAGES - 2);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StRun;
            drain_q   <= '0;
            is_halt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            is_halt_q <= (state_d == StHalted);
        end
    end

    assign is_halt = is_halt_q;

    sat_counter #(
        .W(CNT_W)
    ) u_cyc_cnt (
        .clk_i(clk),
        .rst_i(reset),
        .inc_i(state_q != StHalted),
        .cnt_o(cyc_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk_i(clk),
        .rst_i(reset),
        .inc_i(!en_pc && (state_q != StHalted)),
        .cnt_o(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; a second 3-bit-counter instance checks saturation.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_wait, jump_ex, halt_id;
    logic [2:0] rs1_id, rs2_id, rd_ex;
    logic       rs1_use_id, rs2_use_id, ex_is_load;

    logic        en_pc, flushed, is_halt;
    logic [3:0]  en_stage, flush_stage;
    logic [31:0] cyc_cnt, stall_cnt;

    logic        en_pc_s, flushed_s, is_halt_s;
    logic [3:0]  en_stage_s, flush_stage_s;
    logic [2:0]  cyc_cnt_s, stall_cnt_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.STAGES(5), .RA_W(3), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .mem_wait(mem_wait), .jump_ex(jump_ex),
        .halt_id(halt_id), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_use_id(rs1_use_id),
        .rs2_use_id(rs2_use_id), .rd_ex(rd_ex), .ex_is_load(ex_is_load),
        .en_pc(en_pc), .en_stage(en_stage), .flush_stage(flush_stage), .flushed(flushed),
        .is_halt(is_halt), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.STAGES(5), .RA_W(3), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .mem_wait(mem_wait), .jump_ex(jump_ex),
        .halt_id(halt_id), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_use_id(rs1_use_id),
        .rs2_use_id(rs2_use_id), .rd_ex(rd_ex), .ex_is_load(ex_is_load),
        .en_pc(en_pc_s), .en_stage(en_stage_s), .flush_stage(flush_stage_s),
        .flushed(flushed_s), .is_halt(is_halt_s), .cyc_cnt(cyc_cnt_s),
        .stall_cnt(stall_cnt_s)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_wait   = 1'b0;
        jump_ex    = 1'b0;
        halt_id    = 1'b0;
        rs1_id     = 3'd0;
        rs2_id     = 3'd0;
        rd_ex      = 3'd0;
        rs1_use_id = 1'b0;
        rs2_use_id = 1'b0;
        ex_is_load = 1'b0;
    endtask

    task automatic set_load_use_rs2();
        ex_is_load = 1'b1;
        rd_ex      = 3'd3;
        rs2_id     = 3'd3;
        rs2_use_id = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_en_pc", en_pc, 1);
        check("rst_en_stage", en_stage, 4'b1111);
        check("rst_flush", flush_stage, 4'b0000);
        check("rst_is_halt", is_halt, 0);
        check("rst_cyc", cyc_cnt, 0);
        check("rst_stall", stall_cnt, 0);

        // Idle for 10 cycles.
        repeat (10) tick();
        #1;
        check("idle_cyc", cyc_cnt, 10);
        check("idle_stall", stall_cnt, 0);
        check("idle_en_stage", en_stage, 4'b1111);
        check("sat_cyc", cyc_cnt_s, 7);

        // Load-use via rs2.
        set_load_use_rs2();
        #1;
        check("lu_en_pc", en_pc, 0);
        check("lu_en_stage", en_stage, 4'b1110);
        check("lu_flush", flush_stage, 4'b0010);
        tick();
        clear_inputs();
        #1;
        check("lu_after_en_pc", en_pc, 1);
        check("lu_after_flush", flush_stage, 4'b0000);
        check("lu_stall", stall_cnt, 1);
        check("lu_cyc", cyc_cnt, 11);

        // rd_ex == 0 hazard: rs1 matches but unused, then used.
        ex_is_load = 1'b1;
        rd_ex      = 3'd0;
        rs1_id     = 3'd0;
        rs2_id     = 3'd5;
        rs2_use_id = 1'b1;
        #1;
        check("r0_nouse_en_pc", en_pc, 1);
        rs1_use_id = 1'b1;
        #1;
        check("r0_use_en_pc", en_pc, 0);
        tick();
        clear_inputs();
        #1;
        check("r0_stall", stall_cnt, 2);

        // Jump beats load-use.
        set_load_use_rs2();
        jump_ex = 1'b1;
        #1;
        check("jlu_en_pc", en_pc, 1);
        check("jlu_en_stage", en_stage, 4'b1111);
        check("jlu_flush", flush_stage, 4'b0011);
        check("jlu_flushed", flushed, 1);
        tick();
        clear_inputs();
        #1;
        check("jlu_stall", stall_cnt, 2);
        check("jlu_flushed_off", flushed, 0);

        // mem_wait holds a pending jump for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            mem_wait = 1'b1;
            jump_ex  = 1'b1;
            #1;
            check("mw_en_stage", en_stage, 4'b0000);
            check("mw_flush", flush_stage, 4'b0000);
            check("mw_flushed", flushed, 0);
            tick();
        end
        mem_wait = 1'b0;
        #1;
        check("mw_jump_flush", flush_stage, 4'b0011);
        check("mw_jump_flushed", flushed, 1);
        check("mw_stall", stall_cnt, 5);
        check("mw_cyc", cyc_cnt, 16);
        tick();
        clear_inputs();

        // Halt and drain; a wait cycle extends the drain.
        halt_id = 1'b1;
        #1;
        check("h_en_pc", en_pc, 0);
        check("h_en_stage", en_stage, 4'b1111);
        check("h_flush", flush_stage, 4'b0001);
        tick();
        halt_id = 1'b0;
        set_load_use_rs2();
        #1;
        check("d1_en_pc", en_pc, 0);
        check("d1_en_stage", en_stage, 4'b1111);
        check("d1_flush", flush_stage, 4'b0001);
        tick();
        clear_inputs();
        mem_wait = 1'b1;
        #1;
        check("dw_en_stage", en_stage, 4'b0000);
        tick();
        mem_wait = 1'b0;
        #1;
        check("d2_is_halt", is_halt, 0);
        check("d2_en_pc", en_pc, 0);
        tick();
        #1;
        check("d3_is_halt", is_halt, 0);
        check("d3_flush", flush_stage, 4'b0001);
        tick();
        #1;
        check("hd_is_halt", is_halt, 1);
        check("hd_en_stage", en_stage, 4'b0000);
        check("hd_flush", flush_stage, 4'b0000);
        check("hd_cyc", cyc_cnt, 22);
        check("hd_stall", stall_cnt, 10);
        jump_ex  = 1'b1;
        mem_wait = 1'b1;
        #1;
        check("hd_jump_en_pc", en_pc, 0);
        check("hd_jump_flushed", flushed, 0);
        repeat (3) tick();
        #1;
        check("hd_frozen_cyc", cyc_cnt, 22);
        check("hd_frozen_stall", stall_cnt, 10);
        check("hd_still_halt", is_halt, 1);

        // Asynchronous reset while halted.
        reset = 1'b1;
        #1;
        check("ar_is_halt", is_halt, 0);
        check("ar_cyc", cyc_cnt, 0);
        check("ar_stall", stall_cnt, 0);
        check("ar_sat_cyc", cyc_cnt_s, 0);
        reset = 1'b0;
        clear_inputs();
        #1;
        check("ar_en_pc", en_pc, 1);

        // Halt cancelled by a jump during drain.
        tick();
        halt_id = 1'b1;
        #1;
        check("hc_en_pc", en_pc, 0);
        tick();
        halt_id = 1'b0;
        jump_ex = 1'b1;
        #1;
        check("hc_jump_en_pc", en_pc, 1);
        check("hc_jump_flush", flush_stage, 4'b0011);
        check("hc_flushed", flushed, 1);
        tick();
        clear_inputs();
        #1;
        check("hc_run_en_pc", en_pc, 1);
        check("hc_run_flush", flush_stage, 4'b0000);
        repeat (4) tick();
        #1;
        check("hc_is_halt", is_halt, 0);
        check("hc_cyc", cyc_cnt, 7);
        check("hc_stall", stall_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline control unit for the in-order SIMPLE-style core.
- Replaces the ad-hoc, hard-wired en_*/flush_* wiring with one block that drives the PC enable plus per-register enable and flush for an N-stage pipeline.
- Arbitrates memory wait, taken jump, load-use hazard and halt.
- Owns the halt drain sequence and cycle/stall performance counters.

Parameters:
- STAGES, 5, number of pipeline stages (min 4); there are STAGES-1 pipeline registers, index 0 = IF/ID.
- RA_W, 3, register-address width.
- CNT_W, 32, performance-counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mem_wait  in  1  data memory not ready; freeze the whole pipeline.
- jump_ex  in  1  taken branch/jump resolved in EX.
- halt_id  in  1  HLT instruction present in ID.
- rs1_id  in  RA_W  first source register of the ID instruction.
- rs2_id  in  RA_W  second source register of the ID instruction.
- rs1_use_id  in  1  rs1_id is read.
- rs2_use_id  in  1  rs2_id is read.
- rd_ex  in  RA_W  destination register of the EX instruction.
- ex_is_load  in  1  EX instruction is LD with regwrite.
- en_pc  out  1  PC update enable.
- en_stage  out  STAGES-1  pipeline-register enables.
- flush_stage  out  STAGES-1  pipeline-register synchronous clear (bubble insert).
- flushed  out  1  pulse: jump flush applied this cycle.
- is_halt  out  1  core halted, all older instructions committed.
- cyc_cnt  out  CNT_W  cycles since reset, frozen when halted.
- stall_cnt  out  CNT_W  cycles with en_pc low while not HALTED.

Behaviour:
- FSM states: RUN, DRAIN, HALTED. Reset: state RUN, drain counter 0, counters 0, is_halt 0.
- Outputs are combinational from state and inputs, except is_halt (registered) and the counters.
- Condition priority each cycle, highest first: HALTED > mem_wait > jump_ex > load-use > halt_id > normal.
- HALTED:
  - en_pc=0, en_stage=0, flush_stage=0, is_halt=1.
  - Only reset exits.
- mem_wait:
  - en_pc=0, en_stage all 0, flush_stage 0.
  - Nothing advances; a pending jump_ex or halt is re-evaluated after the wait, since the EX/ID registers are held.
  - In DRAIN the drain counter does not decrement.
- jump_ex (RUN or DRAIN):
  - en_pc=1, all en_stage=1, flush_stage[0]=1 and flush_stage[1]=1, so the IF/ID and ID/EX wrong-path instructions are squashed. flushed=1.
  - In DRAIN: state returns to RUN and the counter clears, because the halt was wrong-path.
- Load-use: ex_is_load && ((rs1_use_id && rs1_id==rd_ex) || (rs2_use_id && rs2_id==rd_ex)).
  - en_pc=0, en_stage[0]=0 (hold IF/ID), flush_stage[1]=1 (bubble into ID/EX), higher stages enabled. One-cycle stall per occurrence.
- halt_id in RUN (no higher condition):
  - en_pc=0, all en_stage=1, flush_stage[0]=1 so nothing follows the HLT.
  - Go to DRAIN with counter = STAGES-2.
- DRAIN:
  - en_pc=0, flush_stage[0]=1, other en_stage=1. Counter decrements per non-waiting cycle.
  - When the counter reaches 0: next state HALTED, is_halt=1 next edge.
  - Ignore halt_id and load-use while draining.
- normal: en_pc=1, en_stage all 1, flush_stage 0, flushed 0.
- Counters:
  - cyc_cnt increments every cycle not in HALTED.
  - stall_cnt increments when en_pc=0 and state!=HALTED.
  - Both saturate at all-ones; no wrap.
- Reset asserted mid-DRAIN or mid-stall: immediate return to the reset values listed above.
- rd_ex==0 is not special: r0 is a real register in this ISA.

Decomposition:
- Package pipe_ctrl_pkg: state enum (RUN, DRAIN, HALTED) and stage-index constants IDX_IFID=0, IDX_IDEX=1.
- Sub-module sat_counter (width parameter, inc, reset), instantiated twice for cyc_cnt and stall_cnt.
- Hazard compare stays inline.

Test Plan:
- Idle after reset, no inputs for 10 cycles -> en_pc=1, en_stage=4'b1111, flush_stage=0, cyc_cnt=10, stall_cnt=0.
- ex_is_load=1, rd_ex=3, rs2_id=3, rs2_use_id=1 for one cycle -> en_pc=0, en_stage=4'b1110, flush_stage=4'b0010; next cycle normal; stall_cnt=1.
- jump_ex=1 together with the load-use condition -> jump wins: en_pc=1, flush_stage=4'b0011, flushed=1, no stall counted.
- mem_wait=1 for 3 cycles with jump_ex=1 -> en_stage=0 for 3 cycles, then flush_stage=4'b0011 on the 4th; stall_cnt=3.
- halt_id=1 with STAGES=5 -> DRAIN 3 cycles with en_pc=0, then is_halt=1; cyc_cnt frozen; mem_wait during DRAIN extends it cycle-for-cycle.
- halt_id entered DRAIN, next cycle jump_ex=1 -> back to RUN, flushed=1, is_halt stays 0. Reset pulsed in HALTED -> is_halt=0 and counters 0 immediately.
